pll_reset_sequencer: RTL and testbench

Lock-qualified reset sequencer in the PLL output clock domain. It synchronises the asynchronous PLL lock flag and requires lock to be stable for a programmable number of cycles. It then releases the core reset, followed after a further delay by the audio-path reset. It re-asserts both resets on loss of lock and keeps a saturating lock-loss counter and a sticky fault flag for the control interface.

---
 rtl/pll_reset_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_pll_reset_sequencer.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_reset_sequencer.sv
// -----------------------------------------------------------------------------
// pll_reset_sequencer
//
// Lock-qualified reset sequencer running in the PLL output clock domain.
// The raw PLL lock flag is synchronised, then it must stay high for
// STABLE_CYCLES consecutive cycles before the core reset is released.
// The audio-path reset is released AUDIO_DELAY cycles later. Losing lock
// after core release drops everything back into reset. It also bumps a
// saturating loss counter and sets a sticky flag.
//
// Parameters
//   SYNC_STAGES    flops in the pll_lock synchroniser (>= 2)
//   STABLE_CYCLES  consecutive locked cycles needed before core release (>= 2)
//   AUDIO_DELAY    cycles from core release to audio release (>= 1)
//
// Ports
//   i_clk           PLL output clock, all logic on the rising edge
//   i_reset         synchronous active-high reset
//   i_pll_lock      raw PLL lock, asynchronous to i_clk
//   i_soft_rst_req  one-cycle pulse that restarts the release sequence
//   i_clear_sticky  pulse that clears o_lock_lost
//   o_core_reset    active-high reset to core logic
//   o_audio_reset   active-high reset to the audio datapath
//   o_ready         high only while fully released (RUN)
//   o_lock_lost     sticky flag, set on any lock loss after core release
//   o_loss_count    lock-loss events, saturating at 255
// -----------------------------------------------------------------------------
module pll_reset_sequencer #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 1024,
  parameter int AUDIO_DELAY   = 256
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_pll_lock,
  input  logic       i_soft_rst_req,
  input  logic       i_clear_sticky,
  output logic       o_core_reset,
  output logic       o_audio_reset,
  output logic       o_ready,
  output logic       o_lock_lost,
  output logic [7:0] o_loss_count
);

  localparam int MAX_DELAY = (STABLE_CYCLES > AUDIO_DELAY) ? STABLE_CYCLES : AUDIO_DELAY;
  localparam int CNT_W     = $clog2(MAX_DELAY) + 1;

  // Terminal counts: the counter is loaded with 1 on the first locked cycle.
  // Reaching STABLE_CYCLES-1 therefore means STABLE_CYCLES locked cycles.
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] AUDIO_LAST  = CNT_W'(AUDIO_DELAY - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  typedef enum logic [2:0] {
    S_WAIT_LOCK = 3'd0,
    S_STABLE    = 3'd1,
    S_CORE_UP   = 3'd2,
    S_RUN       = 3'd3,
    S_FAULT     = 3'd4
  } state_t;

  logic [SYNC_STAGES-1:0] r_sync;
  state_t                 r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_core_reset;
  logic                   r_audio_reset;
  logic                   r_ready;
  logic                   r_lock_lost;
  logic [7:0]             r_loss_count;

  logic                   w_lock_s;
  logic                   w_loss;
  logic                   w_loss_sat;

  assign w_lock_s   = r_sync[SYNC_STAGES-1];
  // A loss only counts once the core has been released.
  assign w_loss     = ((r_state == S_CORE_UP) || (r_state == S_RUN)) && !w_lock_s;
  assign w_loss_sat = (r_loss_count == 8'hFF);

  assign o_core_reset  = r_core_reset;
  assign o_audio_reset = r_audio_reset;
  assign o_ready       = r_ready;
  assign o_lock_lost   = r_lock_lost;
  assign o_loss_count  = r_loss_count;

  // Lock synchroniser. It is deliberately not reset, so a lock that is already
  // stable is seen immediately when the reset is released.
  always_ff @(posedge i_clk) begin
    r_sync <= {r_sync[SYNC_STAGES-2:0], i_pll_lock};
  end

  // Sequencer FSM with its delay counter, reset outputs and loss bookkeeping.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state       <= S_WAIT_LOCK;
      r_cnt         <= CNT_ZERO;
      r_core_reset  <= 1'b1;
      r_audio_reset <= 1'b1;
      r_ready       <= 1'b0;
      r_lock_lost   <= 1'b0;
      r_loss_count  <= 8'd0;
    end else begin
      // A new loss wins over a simultaneous clear of the sticky flag.
      if (w_loss) begin
        r_lock_lost <= 1'b1;
      end else if (i_clear_sticky) begin
        r_lock_lost <= 1'b0;
      end

      if (w_loss && !w_loss_sat) begin
        r_loss_count <= r_loss_count + 8'd1;
      end

      case (r_state)
        S_WAIT_LOCK: begin
          r_core_reset  <= 1'b1;
          r_audio_reset <= 1'b1;
          r_ready       <= 1'b0;
          if (w_lock_s) begin
            r_cnt   <= CNT_ONE;
            r_state <= S_STABLE;
          end else begin
            r_cnt   <= CNT_ZERO;
          end
        end

        S_STABLE: begin
          // Any dropout, or a soft request, restarts qualification from scratch.
          // This is not counted as a loss.
          if (!w_lock_s || i_soft_rst_req) begin
            r_state <= S_WAIT_LOCK;
            r_cnt   <= CNT_ZERO;
          end else if (r_cnt == STABLE_LAST) begin
            r_state      <= S_CORE_UP;
            r_core_reset <= 1'b0;
            r_cnt        <= CNT_ZERO;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end

        S_CORE_UP, S_RUN: begin
          if (w_loss) begin
            r_state       <= S_FAULT;
            r_core_reset  <= 1'b1;
            r_audio_reset <= 1'b1;
            r_ready       <= 1'b0;
            r_cnt         <= CNT_ZERO;
          end else if (i_soft_rst_req) begin
            r_state       <= S_WAIT_LOCK;
            r_core_reset  <= 1'b1;
            r_audio_reset <= 1'b1;
            r_ready       <= 1'b0;
            r_cnt         <= CNT_ZERO;
          end else if (r_state == S_RUN) begin
            r_cnt <= CNT_ZERO;
          end else if (r_cnt == AUDIO_LAST) begin
            r_state       <= S_RUN;
            r_audio_reset <= 1'b0;
            r_ready       <= 1'b1;
            r_cnt         <= CNT_ZERO;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end

        S_FAULT: begin
          // Single recovery cycle. Lock is not re-examined until WAIT_LOCK.
          r_state <= S_WAIT_LOCK;
          r_cnt   <= CNT_ZERO;
        end

        default: begin
          r_state       <= S_WAIT_LOCK;
          r_cnt         <= CNT_ZERO;
          r_core_reset  <= 1'b1;
          r_audio_reset <= 1'b1;
          r_ready       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pll_reset_sequencer
//
// Bench for pll_reset_sequencer with SYNC_STAGES=2, STABLE_CYCLES=16 and
// AUDIO_DELAY=8. A timeline model predicts the outputs after every clock edge.
// It tracks the edge at which qualification started, plus the earliest edge
// at which qualification may start again. Directed scenarios pin key instants
// with literal values. A randomized phase follows.
// -----------------------------------------------------------------------------
module tb_pll_reset_sequencer;

  localparam int SY = 2;
  localparam int S  = 16;
  localparam int A  = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       pll_lock;
  logic       soft_rst_req;
  logic       clear_sticky;
  logic       core_reset;
  logic       audio_reset;
  logic       ready;
  logic       lock_lost;
  logic [7:0] loss_count;

  int n_tests = 0;
  int n_fail  = 0;

  pll_reset_sequencer #(
    .SYNC_STAGES  (SY),
    .STABLE_CYCLES(S),
    .AUDIO_DELAY  (A)
  ) dut (
    .i_clk         (clk),
    .i_reset       (reset),
    .i_pll_lock    (pll_lock),
    .i_soft_rst_req(soft_rst_req),
    .i_clear_sticky(clear_sticky),
    .o_core_reset  (core_reset),
    .o_audio_reset (audio_reset),
    .o_ready       (ready),
    .o_lock_lost   (lock_lost),
    .o_loss_count  (loss_count)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic cycles(input int k);
    repeat (k) @(negedge clk);
  endtask

  // Timeline model: predicts the outputs after each rising edge and checks them
  // against the DUT.
  initial begin : model
    bit lk_q[$];
    bit ls;
    bit loss;
    bit valid;
    int n;
    int q_start;
    int blk;
    int m_cnt;
    bit m_sticky;
    bit e_core;
    bit e_audio;
    valid    = 1'b0;
    n        = 0;
    q_start  = -1;
    blk      = 0;
    m_cnt    = 0;
    m_sticky = 1'b0;
    for (int i = 0; i < SY; i++) lk_q.push_back(1'b0);
    forever begin
      @(posedge clk);
      n++;
      // lock_s at this edge is the pll_lock value sampled SY edges earlier.
      ls = lk_q.pop_front();
      lk_q.push_back(pll_lock);
      loss = 1'b0;
      if (reset) begin
        valid    = 1'b1;
        q_start  = -1;
        blk      = 0;
        m_cnt    = 0;
        m_sticky = 1'b0;
      end else if (valid) begin
        if (q_start < 0) begin
          if (n >= blk && ls) q_start = n;
        end else if (n < q_start + S) begin
          if (!ls || soft_rst_req) q_start = -1;
        end else begin
          if (!ls) begin
            loss    = 1'b1;
            q_start = -1;
            blk     = n + 2;
          end else if (soft_rst_req) begin
            q_start = -1;
          end
        end
        if (loss) begin
          m_sticky = 1'b1;
          if (m_cnt < 255) m_cnt++;
        end else if (clear_sticky) begin
          m_sticky = 1'b0;
        end
      end
      e_core  = !(q_start >= 0 && n >= q_start + S - 1);
      e_audio = !(q_start >= 0 && n >= q_start + S + A - 1);
      #1;
      if (valid) begin
        n_tests++;
        if (core_reset !== e_core || audio_reset !== e_audio || ready !== !e_audio ||
            lock_lost !== m_sticky || loss_count !== 8'(m_cnt)) begin
          n_fail++;
          $display("FAIL model edge %0d: got core=%0b audio=%0b ready=%0b lost=%0b cnt=%0d, expected core=%0b audio=%0b ready=%0b lost=%0b cnt=%0d",
                   n, core_reset, audio_reset, ready, lock_lost, loss_count,
                   e_core, e_audio, !e_audio, m_sticky, m_cnt);
        end
      end
    end
  end

  // Directed scenarios with literal expectations, then randomized stimulus.
  initial begin : stim
    reset        = 1'b1;
    pll_lock     = 1'b0;
    soft_rst_req = 1'b0;
    clear_sticky = 1'b0;
    cycles(4);
    chk("rst_core", core_reset, 1);
    chk("rst_audio", audio_reset, 1);
    chk("rst_ready", ready, 0);
    chk("rst_lost", lock_lost, 0);
    chk("rst_cnt", loss_count, 0);
    reset = 1'b0;
    cycles(5);

    // Clean start: lock sampled at edge 1, lock_s at 3, core at 18, audio at 26.
    pll_lock = 1'b1;
    cycles(17); chk("clean_core_hold", core_reset, 1);
    cycles(1);  chk("clean_core_rel", core_reset, 0);
                chk("clean_audio_hold", audio_reset, 1);
    cycles(7);  chk("clean_ready_hold", ready, 0);
    cycles(1);  chk("clean_audio_rel", audio_reset, 0);
                chk("clean_ready", ready, 1);
                chk("clean_cnt", loss_count, 0);
    cycles(3);

    // Lock loss in RUN: the drop reaches the outputs at edge 3.
    pll_lock = 1'b0;
    cycles(2);  chk("loss_core_pre", core_reset, 0);
                chk("loss_ready_pre", ready, 1);
    cycles(1);  chk("loss_core", core_reset, 1);
                chk("loss_audio", audio_reset, 1);
                chk("loss_ready", ready, 0);
                chk("loss_cnt", loss_count, 1);
                chk("loss_lost", lock_lost, 1);
    cycles(5);

    // Glitch during qualification: lock_s is low at edge 12, so a new start at 13.
    pll_lock = 1'b1;
    cycles(9);
    pll_lock = 1'b0;
    cycles(1);
    pll_lock = 1'b1;
    cycles(8);  chk("glitch_core_18", core_reset, 1);
    cycles(9);  chk("glitch_core_27", core_reset, 1);
    cycles(1);  chk("glitch_core_rel", core_reset, 0);
    cycles(8);  chk("glitch_ready", ready, 1);
                chk("glitch_cnt", loss_count, 1);

    // Soft reset in RUN.
    cycles(2);
    soft_rst_req = 1'b1;
    cycles(1);
    soft_rst_req = 1'b0;
    chk("soft_core", core_reset, 1);
    chk("soft_ready", ready, 0);
    chk("soft_cnt", loss_count, 1);
    cycles(15); chk("soft_core_hold", core_reset, 1);
    cycles(1);  chk("soft_core_rel", core_reset, 0);
    cycles(8);  chk("soft_ready_again", ready, 1);

    // Soft request in the same cycle as lock_s falling is counted as a loss.
    cycles(2);
    pll_lock = 1'b0;
    cycles(2);
    soft_rst_req = 1'b1;
    cycles(1);
    soft_rst_req = 1'b0;
    chk("softloss_cnt", loss_count, 2);
    chk("softloss_core", core_reset, 1);
    cycles(4);

    // Saturation: 255 more losses give 257 in total.
    clear_sticky = 1'b1;
    cycles(1);
    clear_sticky = 1'b0;
    chk("clr1_lost", lock_lost, 0);
    for (int i = 0; i < 255; i++) begin
      pll_lock = 1'b1;
      cycles(19);
      pll_lock = 1'b0;
      cycles(5);
    end
    chk("sat_cnt", loss_count, 255);
    chk("sat_lost", lock_lost, 1);
    clear_sticky = 1'b1;
    cycles(1);
    clear_sticky = 1'b0;
    chk("clr2_lost", lock_lost, 0);
    chk("clr2_cnt", loss_count, 255);
    pll_lock = 1'b1;
    cycles(19);
    pll_lock = 1'b0;
    cycles(2);
    clear_sticky = 1'b1;
    cycles(1);
    clear_sticky = 1'b0;
    chk("clrloss_lost", lock_lost, 1);
    chk("clrloss_cnt", loss_count, 255);
    cycles(2);
    clear_sticky = 1'b1;
    cycles(1);
    clear_sticky = 1'b0;
    chk("clr3_lost", lock_lost, 0);
    chk("clr3_cnt", loss_count, 255);

    // Reset asserted in CORE_UP, three cycles after the core release.
    pll_lock = 1'b1;
    cycles(18); chk("rcu_core_pre", core_reset, 0);
    cycles(3);
    reset = 1'b1;
    cycles(1);
    reset = 1'b0;
    chk("rcu_core", core_reset, 1);
    chk("rcu_cnt", loss_count, 0);
    chk("rcu_lost", lock_lost, 0);
    cycles(15); chk("rcu_core_hold", core_reset, 1);
    cycles(1);  chk("rcu_core_rel", core_reset, 0);

    // Randomized phase: held lock levels with occasional requests and resets.
    for (int seg = 0; seg < 100; seg++) begin
      int len;
      pll_lock = ($urandom_range(0, 3) != 0);
      len = $urandom_range(1, 45);
      for (int c = 0; c < len; c++) begin
        soft_rst_req = ($urandom_range(0, 63) == 0);
        clear_sticky = ($urandom_range(0, 31) == 0);
        reset        = ($urandom_range(0, 399) == 0);
        cycles(1);
      end
    end
    soft_rst_req = 1'b0;
    clear_sticky = 1'b0;
    reset        = 1'b0;
    cycles(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
